open_list_minq: RTL and testbench

//  A* open list: stores frontier nodes (x,y,g,h); on request, extracts the node with minimum f=g+h.

---
 rtl/open_list_minq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_open_list_minq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/open_list_minq.sv
// A* open list: holds frontier nodes and extracts the minimum-f (g+h) node by a linear scan.
// Optional build macro OPEN_LIST_DEDUP_EN: inserts of an existing (x,y) keep only the lowest g.
module open_list_minq #(
    parameter int unsigned DEPTH   = 400,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned COST_W  = 12,
    parameter int unsigned IDX_W   = 9
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               ins_valid,
    output logic               ins_ready,
    input  logic [COORD_W-1:0] ins_x,
    input  logic [COORD_W-1:0] ins_y,
    input  logic [COST_W-1:0]  ins_g,
    input  logic [COST_W-1:0]  ins_h,
    input  logic               pop_req,
    output logic               pop_valid,
    output logic [COORD_W-1:0] pop_x,
    output logic [COORD_W-1:0] pop_y,
    output logic [COST_W-1:0]  pop_g,
    output logic [COST_W-1:0]  pop_h,
    output logic               pop_err,
    output logic [IDX_W-1:0]   count,
    output logic               empty,
    output logic               full,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REMOVE
`ifdef OPEN_LIST_DEDUP_EN
        , S_DSCAN
`endif
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic [COST_W:0]     best_f_q, best_f_d;
    logic [COST_W-1:0]   best_h_q, best_h_d;
    logic                pop_valid_q, pop_valid_d;
    logic                pop_err_q, pop_err_d;
    logic [COORD_W-1:0]  pop_x_q, pop_x_d, pop_y_q, pop_y_d;
    logic [COST_W-1:0]   pop_g_q, pop_g_d, pop_h_q, pop_h_d;

`ifdef OPEN_LIST_DEDUP_EN
    logic [COORD_W-1:0]  hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    logic [COST_W-1:0]   hold_g_q, hold_g_d, hold_h_q, hold_h_d;
    logic                matched_q, matched_d;
    logic                match_now;
`endif

    // Node storage: not reset, only the first count_q entries are meaningful.
    logic [COORD_W-1:0]  ent_x_q [DEPTH];
    logic [COORD_W-1:0]  ent_y_q [DEPTH];
    logic [COST_W-1:0]   ent_g_q [DEPTH];
    logic [COST_W-1:0]   ent_h_q [DEPTH];

    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [COORD_W-1:0]  wr_x, wr_y;
    logic [COST_W-1:0]   wr_g, wr_h;

    logic [IDX_W-1:0]    last_idx;
    logic [COST_W:0]     cur_f;
    logic                is_full, is_empty;

    assign last_idx  = count_q - IDX_W'(1);
    assign cur_f     = {1'b0, ent_g_q[idx_q]} + {1'b0, ent_h_q[idx_q]};
    assign is_full   = (count_q == IDX_W'(DEPTH));
    assign is_empty  = (count_q == '0);

    assign ins_ready = (state_q == S_IDLE) && !is_full;
    assign busy      = (state_q != S_IDLE);
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = count_q;
    assign pop_valid = pop_valid_q;
    assign pop_err   = pop_err_q;
    assign pop_x     = pop_x_q;
    assign pop_y     = pop_y_q;
    assign pop_g     = pop_g_q;
    assign pop_h     = pop_h_q;

`ifdef OPEN_LIST_DEDUP_EN
    assign match_now = (ent_x_q[idx_q] == hold_x_q) && (ent_y_q[idx_q] == hold_y_q);
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_f_d    = best_f_q;
        best_h_d    = best_h_q;
        pop_valid_d = 1'b0;
        pop_err_d   = 1'b0;
        pop_x_d     = pop_x_q;
        pop_y_d     = pop_y_q;
        pop_g_d     = pop_g_q;
        pop_h_d     = pop_h_q;
        wr_en       = 1'b0;
        wr_idx      = count_q;
        wr_x        = ins_x;
        wr_y        = ins_y;
        wr_g        = ins_g;
        wr_h        = ins_h;
`ifdef OPEN_LIST_DEDUP_EN
        hold_x_d    = hold_x_q;
        hold_y_d    = hold_y_q;
        hold_g_d    = hold_g_q;
        hold_h_d    = hold_h_q;
        matched_d   = matched_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (ins_valid && ins_ready) begin
`ifdef OPEN_LIST_DEDUP_EN
                    if (is_empty) begin
                        wr_en   = 1'b1;
                        count_d = count_q + IDX_W'(1);
                    end else begin
                        hold_x_d  = ins_x;
                        hold_y_d  = ins_y;
                        hold_g_d  = ins_g;
                        hold_h_d  = ins_h;
                        matched_d = 1'b0;
                        idx_d     = '0;
                        state_d   = S_DSCAN;
                    end
`else
                    wr_en   = 1'b1;
                    count_d = count_q + IDX_W'(1);
`endif
                end else if (pop_req) begin
                    if (is_empty) begin
                        pop_err_d = 1'b1;
                    end else begin
                        idx_d      = '0;
                        best_idx_d = '0;
                        best_f_d   = '1;
                        best_h_d   = '1;
                        state_d    = S_SCAN;
                    end
                end
            end

            S_SCAN: begin
                // Strict compares keep the lower index on a full (f,h) tie.
                if ((cur_f < best_f_q) ||
                    ((cur_f == best_f_q) && (ent_h_q[idx_q] < best_h_q))) begin
                    best_idx_d = idx_q;
                    best_f_d   = cur_f;
                    best_h_d   = ent_h_q[idx_q];
                end
                if (idx_q == last_idx) begin
                    state_d = S_REMOVE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_REMOVE: begin
                pop_valid_d = 1'b1;
                pop_x_d     = ent_x_q[best_idx_q];
                pop_y_d     = ent_y_q[best_idx_q];
                pop_g_d     = ent_g_q[best_idx_q];
                pop_h_d     = ent_h_q[best_idx_q];
                // Fill the hole with the last entry so storage stays packed.
                wr_en       = 1'b1;
                wr_idx      = best_idx_q;
                wr_x        = ent_x_q[last_idx];
                wr_y        = ent_y_q[last_idx];
                wr_g        = ent_g_q[last_idx];
                wr_h        = ent_h_q[last_idx];
                count_d     = last_idx;
                state_d     = S_IDLE;
            end

`ifdef OPEN_LIST_DEDUP_EN
            S_DSCAN: begin
                wr_x = hold_x_q;
                wr_y = hold_y_q;
                wr_g = hold_g_q;
                wr_h = hold_h_q;
                if (match_now) begin
                    matched_d = 1'b1;
                    if (hold_g_q < ent_g_q[idx_q]) begin
                        wr_en  = 1'b1;
                        wr_idx = idx_q;
                    end
                end
                if (idx_q == last_idx) begin
                    if (!matched_q && !match_now) begin
                        wr_en   = 1'b1;
                        wr_idx  = count_q;
                        count_d = count_q + IDX_W'(1);
                    end
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_f_q    <= '1;
            best_h_q    <= '1;
            pop_valid_q <= 1'b0;
            pop_err_q   <= 1'b0;
            pop_x_q     <= '0;
            pop_y_q     <= '0;
            pop_g_q     <= '0;
            pop_h_q     <= '0;
`ifdef OPEN_LIST_DEDUP_EN
            hold_x_q    <= '0;
            hold_y_q    <= '0;
            hold_g_q    <= '0;
            hold_h_q    <= '0;
            matched_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_f_q    <= best_f_d;
            best_h_q    <= best_h_d;
            pop_valid_q <= pop_valid_d;
            pop_err_q   <= pop_err_d;
            pop_x_q     <= pop_x_d;
            pop_y_q     <= pop_y_d;
            pop_g_q     <= pop_g_d;
            pop_h_q     <= pop_h_d;
`ifdef OPEN_LIST_DEDUP_EN
            hold_x_q    <= hold_x_d;
            hold_y_q    <= hold_y_d;
            hold_g_q    <= hold_g_d;
            hold_h_q    <= hold_h_d;
            matched_q   <= matched_d;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            ent_x_q[wr_idx] <= wr_x;
            ent_y_q[wr_idx] <= wr_y;
            ent_g_q[wr_idx] <= wr_g;
            ent_h_q[wr_idx] <= wr_h;
        end
    end

endmodule

// File: tb/tb_open_list_minq.sv
// Directed bench for open_list_minq at DEPTH=4: table-driven insert/pop vectors plus
// hand sequences for full, insert/pop collision, reset mid-scan and (if built) dedup.
module tb_open_list_minq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [7:0]  ins_x = '0, ins_y = '0;
    logic [11:0] ins_g = '0, ins_h = '0;
    logic        pop_req = 1'b0;
    logic        pop_valid;
    logic [7:0]  pop_x, pop_y;
    logic [11:0] pop_g, pop_h;
    logic        pop_err;
    logic [2:0]  count;
    logic        empty, full, busy;

    int checks = 0;
    int errors = 0;

    open_list_minq #(.DEPTH(4), .COORD_W(8), .COST_W(12), .IDX_W(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_x(ins_x), .ins_y(ins_y), .ins_g(ins_g), .ins_h(ins_h),
        .pop_req(pop_req), .pop_valid(pop_valid),
        .pop_x(pop_x), .pop_y(pop_y), .pop_g(pop_g), .pop_h(pop_h),
        .pop_err(pop_err), .count(count), .empty(empty), .full(full), .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          is_pop;
        bit          exp_err;
        logic [7:0]  x, y;     // insert data, or expected pop data
        logic [11:0] g, h;
        int          lat;      // expected edges from pop accept to pop_valid/pop_err
        int          cnt;      // expected count afterwards
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_ins(input logic [7:0] x, y, input logic [11:0] g, h, input int exp_cnt);
        int n;
        chk("ins_ready", 32'(ins_ready), 1);
        ins_valid = 1'b1; ins_x = x; ins_y = y; ins_g = g; ins_h = h;
        @(negedge Clk);
        ins_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("ins_count", 32'(count), exp_cnt);
    endtask

    task automatic do_pop(input vec_t v);
        int  cyc;
        bit  got_v, got_e;
        pop_req = 1'b1;
        cyc = 0; got_v = 1'b0; got_e = 1'b0;
        while (!got_v && !got_e && cyc < 40) begin
            @(negedge Clk);
            cyc++;
            got_v = pop_valid;
            got_e = pop_err;
        end
        pop_req = 1'b0;
        chk("pop_done", 32'(got_v | got_e), 1);
        chk("pop_err", 32'(got_e), 32'(v.exp_err));
        chk("pop_lat", 32'(cyc - 1), 32'(v.lat));
        if (!v.exp_err) begin
            chk("pop_x", 32'(pop_x), 32'(v.x));
            chk("pop_y", 32'(pop_y), 32'(v.y));
            chk("pop_g", 32'(pop_g), 32'(v.g));
            chk("pop_h", 32'(pop_h), 32'(v.h));
        end
        @(negedge Clk);
        chk("pop_pulse", 32'(pop_valid | pop_err), 0);
        chk("pop_count", 32'(count), 32'(v.cnt));
    endtask

    task automatic apply(input vec_t v);
        if (v.is_pop) do_pop(v);
        else do_ins(v.x, v.y, v.g, v.h, v.cnt);
    endtask

    function automatic vec_t mk(input bit p, input bit e, input logic [7:0] x, y,
                                input logic [11:0] g, h, input int lat, input int cnt);
        vec_t v;
        v.is_pop = p; v.exp_err = e; v.x = x; v.y = y; v.g = g; v.h = h;
        v.lat = lat; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t basic[7];
        vec_t drain[4];
        int   n;
        bit   seen;

        basic[0] = mk(0, 0, 3, 4, 5, 10, 0, 1);
        basic[1] = mk(0, 0, 7, 1, 2, 6,  0, 2);
        basic[2] = mk(0, 0, 2, 2, 4, 4,  0, 3);
        basic[3] = mk(1, 0, 2, 2, 4, 4,  4, 2);   // f=8 tie with (7,1); lower h wins
        basic[4] = mk(1, 0, 7, 1, 2, 6,  3, 1);
        basic[5] = mk(1, 0, 3, 4, 5, 10, 2, 0);
        basic[6] = mk(1, 1, 0, 0, 0, 0,  0, 0);   // pop while empty

        drain[0] = mk(1, 0, 11, 1, 1, 1, 5, 3);
        drain[1] = mk(1, 0, 10, 1, 3, 3, 4, 2);
        drain[2] = mk(1, 0, 12, 1, 7, 0, 3, 1);
        drain[3] = mk(1, 0, 13, 1, 2, 9, 2, 0);

        // Reset state
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ready", 32'(ins_ready), 1);
        chk("rst_pop_valid", 32'(pop_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pop_x", 32'(pop_x), 0);

        // Ordered extraction and empty-pop error
        for (int i = 0; i < 7; i++) apply(basic[i]);
        chk("basic_empty", 32'(empty), 1);

        // Fill to DEPTH, rejected 5th insert, pop frees a slot
        do_ins(10, 1, 3, 3, 1);
        do_ins(11, 1, 1, 1, 2);
        do_ins(12, 1, 7, 0, 3);
        do_ins(13, 1, 2, 9, 4);
        chk("full_flag", 32'(full), 1);
        chk("full_ready", 32'(ins_ready), 0);
        ins_valid = 1'b1; ins_x = 14; ins_y = 1; ins_g = 0; ins_h = 0;
        @(negedge Clk);
        ins_valid = 1'b0;
        @(negedge Clk);
        chk("full_ignored_count", 32'(count), 4);
        do_pop(drain[0]);
        chk("after_pop_full", 32'(full), 0);
        chk("after_pop_ready", 32'(ins_ready), 1);
        for (int i = 1; i < 4; i++) do_pop(drain[i]);

        // Insert and pop requested in the same IDLE cycle: insert first
        do_ins(1, 1, 5, 5, 1);
        ins_valid = 1'b1; ins_x = 9; ins_y = 9; ins_g = 0; ins_h = 1;
        pop_req = 1'b1;
        @(negedge Clk);
        ins_valid = 1'b0;
        n = 1; seen = pop_valid;
        while (!seen && n < 40) begin
            @(negedge Clk);
            n++;
            seen = pop_valid;
        end
        pop_req = 1'b0;
        chk("coll_valid", 32'(seen), 1);
`ifdef OPEN_LIST_DEDUP_EN
        chk("coll_lat", 32'(n), 6);
`else
        chk("coll_lat", 32'(n), 5);
`endif
        chk("coll_x", 32'(pop_x), 9);
        chk("coll_y", 32'(pop_y), 9);
        chk("coll_g", 32'(pop_g), 0);
        @(negedge Clk);
        chk("coll_count", 32'(count), 1);
        do_pop(mk(1, 0, 1, 1, 5, 5, 2, 0));

        // Reset two cycles into SCAN aborts the pop
        do_ins(20, 0, 1, 1, 1);
        do_ins(21, 0, 2, 2, 2);
        do_ins(22, 0, 3, 3, 3);
        pop_req = 1'b1;
        repeat (3) @(negedge Clk);
        chk("scan_busy", 32'(busy), 1);
        Reset = 1'b1;
        pop_req = 1'b0;
        #1;
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        @(negedge Clk);
        Reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            seen = seen | pop_valid;
        end
        chk("rst_mid_no_valid", 32'(seen), 0);
        chk("rst_mid_empty", 32'(empty), 1);
        chk("rst_mid_busy2", 32'(busy), 0);

`ifdef OPEN_LIST_DEDUP_EN
        // Duplicate coordinates keep only the lowest g
        do_ins(5, 5, 9, 3, 1);
        do_ins(5, 5, 6, 3, 1);
        do_ins(5, 5, 8, 3, 1);
        do_pop(mk(1, 0, 5, 5, 6, 3, 2, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
